// File: rtl/ptt_pkg.sv
// Shared types and constants for the programmable truth table.
package ptt_pkg;

    // Controller states. INIT clears the table after reset; IDLE serves
    // writes and lookups. There are no other states.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Default value driven on output bits whose don't-care mask bit is set.
    localparam logic DC_FILL_DEFAULT = 1'b0;

endpackage

// File: rtl/ptt_mem.sv
// Register-array storage for the truth table: one synchronous write port and
// one combinational read port. The parent handles write-first bypass.
module ptt_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Table contents carry no reset; the parent's INIT sweep clears them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_truth_table.sv
// Programmable registered truth table with per-bit don't-care masks.
// Run-time loadable through a write port; lookups use valid/ready with one
// cycle of latency and full throughput.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_INIT | clearing entry[init_ptr] each cycle; writes dropped, no lookups
//  ST_IDLE | normal operation: writes and lookups accepted
module prog_truth_table
    import ptt_pkg::*;
#(
    parameter int   IN_W    = 4,
    parameter int   OUT_W   = 3,
    parameter logic DC_FILL = DC_FILL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic             busy,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_addr,
    input  logic [OUT_W-1:0] wr_f,
    input  logic [OUT_W-1:0] wr_dc,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_f,
    output logic [OUT_W-1:0] out_dc
);

    localparam int ENTRY_W = 2 * OUT_W;

    state_t            state;
    logic [IN_W-1:0]   init_ptr;
    logic              init_last;

    logic              wr_accept;
    logic              mem_we;
    logic [IN_W-1:0]   mem_waddr;
    logic [ENTRY_W-1:0] mem_wdata;
    logic [ENTRY_W-1:0] mem_rdata;

    logic              bypass;
    logic [OUT_W-1:0]  hit_f;
    logic [OUT_W-1:0]  hit_dc;
    logic [OUT_W-1:0]  fill_f;
    logic              lookup_fire;

    // Terminal flag for the clearing sweep: the last entry is all-ones.
    assign init_last = &init_ptr;

    // Writes only land once the table is initialised; the reset cycle is
    // excluded so nothing leaks into a table that is about to be cleared.
    assign wr_accept = wr_en && (state == ST_IDLE) && !rst;

    // During INIT the sweep owns the write port; afterwards the user does.
    always_comb begin
        mem_we    = wr_accept;
        mem_waddr = wr_addr;
        mem_wdata = {wr_f, wr_dc};
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_ptr;
            mem_wdata = '0;
        end
    end

    ptt_mem #(
        .ADDR_W (IN_W),
        .DATA_W (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (in_a),
        .rdata (mem_rdata)
    );

    // A same-cycle write to the looked-up address wins over the stored entry.
    assign bypass = wr_accept && (wr_addr == in_a);

    // Select the entry seen by the lookup, honouring write-first ordering.
    always_comb begin
        hit_f  = mem_rdata[ENTRY_W-1:OUT_W];
        hit_dc = mem_rdata[OUT_W-1:0];
        if (bypass) begin
            hit_f  = wr_f;
            hit_dc = wr_dc;
        end
    end

    // Don't-care bits are forced to the fill value rather than left floating.
    assign fill_f = (hit_f & ~hit_dc) | ({OUT_W{DC_FILL}} & hit_dc);

    assign in_ready    = (state == ST_IDLE) && (!out_valid || out_ready);
    assign lookup_fire = in_valid && in_ready;

    // Controller: clearing sweep after reset, then idle forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_ptr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    busy <= 1'b0;
                end
                default: begin
                    state    <= ST_INIT;
                    init_ptr <= '0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

    // Output register: load on accepted lookup, drop valid on drain,
    // hold everything while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_f     <= '0;
            out_dc    <= '0;
        end else if (lookup_fire) begin
            out_valid <= 1'b1;
            out_f     <= fill_f;
            out_dc    <= hit_dc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_truth_table.sv
// Directed bench for prog_truth_table with a behavioural reference model.
// Two instances share stimulus: one with DC_FILL=0, one with DC_FILL=1.
module tb_prog_truth_table;

    localparam int IN_W  = 4;
    localparam int OUT_W = 3;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             wr_en;
    logic [IN_W-1:0]  wr_addr;
    logic [OUT_W-1:0] wr_f;
    logic [OUT_W-1:0] wr_dc;
    logic             in_valid;
    logic [IN_W-1:0]  in_a;
    logic             out_ready;

    logic             busy0, in_ready0, out_valid0;
    logic [OUT_W-1:0] out_f0, out_dc0;
    logic             busy1, in_ready1, out_valid1;
    logic [OUT_W-1:0] out_f1, out_dc1;

    prog_truth_table #(.IN_W(IN_W), .OUT_W(OUT_W), .DC_FILL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_f(wr_f), .wr_dc(wr_dc),
        .in_valid(in_valid), .in_ready(in_ready0), .in_a(in_a),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_f(out_f0), .out_dc(out_dc0)
    );

    prog_truth_table #(.IN_W(IN_W), .OUT_W(OUT_W), .DC_FILL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_f(wr_f), .wr_dc(wr_dc),
        .in_valid(in_valid), .in_ready(in_ready1), .in_a(in_a),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_f(out_f1), .out_dc(out_dc1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: table contents, remaining sweep cycles, output slot.
    logic [OUT_W-1:0] m_tf  [DEPTH];
    logic [OUT_W-1:0] m_tdc [DEPTH];
    int               m_busy_left = DEPTH;
    bit               m_valid = 1'b0;
    logic [OUT_W-1:0] m_f0 = '0;
    logic [OUT_W-1:0] m_f1 = '0;
    logic [OUT_W-1:0] m_dc = '0;
    bit               m_acc;

    always @(posedge clk) begin
        m_acc = in_valid && (m_busy_left == 0) && (!m_valid || out_ready);
        if (rst) begin
            m_busy_left = DEPTH;
            m_valid     = 1'b0;
            m_f0        = '0;
            m_f1        = '0;
            m_dc        = '0;
            for (int i = 0; i < DEPTH; i++) begin
                m_tf[i]  = '0;
                m_tdc[i] = '0;
            end
        end else if (m_busy_left > 0) begin
            m_busy_left = m_busy_left - 1;
        end else begin
            if (wr_en) begin
                m_tf[wr_addr]  = wr_f;
                m_tdc[wr_addr] = wr_dc;
            end
            if (m_acc) begin
                m_valid = 1'b1;
                m_f0    = m_tf[in_a] & ~m_tdc[in_a];
                m_f1    = m_tf[in_a] | m_tdc[in_a];
                m_dc    = m_tdc[in_a];
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    bit m_rdy;
    always @(posedge clk) begin
        #1;
        m_rdy = (m_busy_left == 0) && (!m_valid || out_ready);
        check("busy0",      busy0,      m_busy_left > 0);
        check("in_ready0",  in_ready0,  m_rdy);
        check("out_valid0", out_valid0, m_valid);
        check("out_f0",     out_f0,     m_f0);
        check("out_dc0",    out_dc0,    m_dc);
        check("busy1",      busy1,      m_busy_left > 0);
        check("in_ready1",  in_ready1,  m_rdy);
        check("out_valid1", out_valid1, m_valid);
        check("out_f1",     out_f1,     m_f1);
        check("out_dc1",    out_dc1,    m_dc);
    end

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy0) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write_entry(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] f,
                               input logic [OUT_W-1:0] dc);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_f    = f;
        wr_dc   = dc;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic lookup(input logic [IN_W-1:0] a);
        in_valid  = 1'b1;
        in_a      = a;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_f = '0; wr_dc = '0;
        in_valid = 1'b0; in_a = '0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_in_ready", in_ready0, 0);
        rst = 1'b0;

        // Sweep length, with a write to a7 held during INIT (must be dropped).
        wr_en = 1'b1; wr_addr = 4'd7; wr_f = 3'b110; wr_dc = 3'b000;
        count_busy(n);
        wr_en = 1'b0;
        check("busy_cycles", n, 16);

        // Every entry reads back cleared, back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_a     = 4'(i);
            @(negedge clk);
            check("sweep_valid", out_valid0, 1);
            check("sweep_f", out_f0, 0);
            check("sweep_dc", out_dc0, 0);
        end
        in_valid = 1'b0;

        lookup(4'd7);
        check("init_wr_dropped", out_f0, 0);

        // Don't-care fill on both instances.
        write_entry(4'd3, 3'b011, 3'b100);
        lookup(4'd3);
        check("a3_f_fill0", out_f0, 3'b011);
        check("a3_dc", out_dc0, 3'b100);
        check("a3_f_fill1", out_f1, 3'b111);

        // Same-cycle write and lookup to one address.
        wr_en = 1'b1; wr_addr = 4'd5; wr_f = 3'b101; wr_dc = 3'b000;
        in_valid = 1'b1; in_a = 4'd5;
        @(negedge clk);
        wr_en = 1'b0; in_valid = 1'b0;
        check("write_first", out_f0, 3'b101);

        // Stall then stream 1, 2, 4.
        write_entry(4'd1, 3'b001, 3'b010);
        write_entry(4'd2, 3'b110, 3'b000);
        write_entry(4'd4, 3'b100, 3'b001);
        out_ready = 1'b1; in_valid = 1'b1; in_a = 4'd1;
        @(negedge clk);
        check("t4_first", out_f0, 3'b001);
        out_ready = 1'b0; in_a = 4'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", out_valid0, 1);
            check("t4_hold_f", out_f0, 3'b001);
            check("t4_hold_dc", out_dc0, 3'b010);
            check("t4_hold_ready", in_ready0, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_second", out_f0, 3'b110);
        in_a = 4'd4;
        @(negedge clk);
        check("t4_third_f", out_f0, 3'b100);
        check("t4_third_dc", out_dc0, 3'b001);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_drain_valid", out_valid0, 0);
        check("t4_drain_keep", out_f0, 3'b100);

        // Reset while a result is held.
        in_valid = 1'b1; in_a = 4'd2; out_ready = 1'b0;
        @(negedge clk);
        check("t6_pre_valid", out_valid0, 1);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t6_valid", out_valid0, 0);
        check("t6_busy", busy0, 1);
        check("t6_f", out_f0, 0);
        rst = 1'b0;
        count_busy(n);
        check("t6_busy_cycles", n, 16);
        lookup(4'd3);
        check("t6_table_lost_f", out_f0, 0);
        check("t6_table_lost_dc", out_dc0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
